// File: rtl/fir_sample_feeder_if.sv
// Sample and result streams of the FIR feeder, bundled with direction views.
interface fir_sample_feeder_if #(
  parameter int DW = 8,
  parameter int OW = 18
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;

  // Producer of samples and consumer of results.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  // The feeder itself: consumes samples, produces results.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Flow-controlled front end for a free-running, registered FIR core.
// Keeps the sample window that feeds the FIR, tracks which accepts produce
// a result through a tag pipeline matching the FIR latency, and parks the
// results in a small FIFO. Credits cover both queued and in-flight results,
// so a push can never find the FIFO full.
module fir_sample_feeder #(
  parameter int TAPS    = 8,
  parameter int DW      = 8,
  parameter int OW      = 18,
  parameter int FIR_LAT = 1,
  parameter int RDEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  fir_sample_feeder_if.slave          bus,
  output logic [TAPS-1:0][DW-1:0]     win,
  input  logic [OW-1:0]               fir_dout,
  output logic [$clog2(TAPS+1)-1:0]   fill_cnt
);
  localparam int FW  = $clog2(TAPS + 1);
  localparam int PW  = $clog2(RDEPTH);
  localparam int CW  = $clog2(RDEPTH + 1);
  localparam int NST = FIR_LAT + 1;
  localparam int SW  = $clog2(RDEPTH + NST + 1) + 1;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    STALL
  } state_t;

  state_t                  state_q, state_d;
  logic [TAPS-1:0][DW-1:0] win_q, win_d, win_shift;
  logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [NST-1:0]          tag_q, tag_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [OW-1:0]           mem_q [RDEPTH];
  logic [SW-1:0]           inflight_d;
  logic [SW-1:0]           credit_used_d;
  logic                    accept;
  logic                    issue;
  logic                    push_en;
  logic                    pop;

  // Ready comes only from registered state (the STALL decision was made
  // from next-cycle counts), so m_ready never reaches s_ready combinationally.
  assign bus.s_ready = rst_n && !flush && (state_q != STALL);
  assign bus.m_valid = (count_q != '0);
  assign bus.m_data  = bus.m_valid ? mem_q[rd_ptr_q] : '0;
  assign win         = win_q;
  assign fill_cnt    = fill_cnt_q;

  assign accept = bus.s_valid && bus.s_ready;
  assign pop    = bus.m_valid && bus.m_ready && !flush;

  // Window after one shift: oldest drops out, new sample enters at the top.
  always_comb begin
    win_shift = '0;
    for (int i = 0; i < TAPS - 1; i++) begin
      win_shift[i] = win_q[i + 1];
    end
    win_shift[TAPS-1] = bus.s_data;
  end

  // Next-state for window, fill count, tag pipe, FIFO pointers and FSM.
  always_comb begin
    win_d         = win_q;
    fill_cnt_d    = fill_cnt_q;
    issue         = 1'b0;
    tag_d         = '0;
    push_en       = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_d    = '0;
    credit_used_d = '0;
    state_d       = state_q;

    if (accept) begin
      win_d = win_shift;
      if (fill_cnt_q != FW'(TAPS)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
      // A result exists only once the shifted window is completely full.
      issue = (fill_cnt_d == FW'(TAPS));
    end

    // Tag stage 0 loads the issue bit every cycle; the last stage marks the
    // edge at which fir_dout holds the result for that accept.
    tag_d[0] = issue;
    for (int i = 1; i < NST; i++) begin
      tag_d[i] = tag_q[i - 1];
    end
    push_en = tag_q[NST-1];

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_en) - CW'(pop);

    if (flush) begin
      win_d      = '0;
      fill_cnt_d = '0;
      tag_d      = '0;
      push_en    = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end

    for (int i = 0; i < NST; i++) begin
      inflight_d = inflight_d + SW'(tag_d[i]);
    end
    credit_used_d = SW'(count_d) + inflight_d;

    // FILL until the window is full; afterwards RUN or STALL by credits.
    if (flush || (fill_cnt_d != FW'(TAPS))) begin
      state_d = FILL;
    end else if (credit_used_d >= SW'(RDEPTH)) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      win_q      <= '0;
      fill_cnt_q <= '0;
      tag_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      fill_cnt_q <= fill_cnt_d;
      tag_q      <= tag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Result storage; contents are only visible through m_data when non-empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= fir_dout;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: FIR modelled as a registered all-ones sum of
// the window; expectations come from a sample-history/result-queue model.
module tb_fir_sample_feeder;
  localparam int TAPS    = 8;
  localparam int DW      = 8;
  localparam int OW      = 18;
  localparam int FIR_LAT = 1;
  localparam int RDEPTH  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic [TAPS-1:0][DW-1:0] win;
  logic [OW-1:0]           fir_dout;
  logic [3:0]              fill_cnt;
  logic [OW-1:0]           fir_sum;

  fir_sample_feeder_if #(.DW(DW), .OW(OW)) bus ();

  fir_sample_feeder #(
    .TAPS(TAPS), .DW(DW), .OW(OW), .FIR_LAT(FIR_LAT), .RDEPTH(RDEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus),
    .win(win),
    .fir_dout(fir_dout),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  // FIR stand-in: registered sum of the window, coefficients all 1
  always_comb begin
    fir_sum = '0;
    for (int k = 0; k < TAPS; k++) fir_sum = fir_sum + OW'(win[k]);
  end
  always @(posedge clk) fir_dout <= fir_sum;

  // reference model: samples since last clear, and results issued-not-popped
  typedef struct {
    int     val;
    longint avail;
  } res_t;
  int     samp_q[$];
  int     fill_m = 0;
  res_t   res_q[$];
  longint edges = 0;
  int     popped[$];
  longint popped_at[$];

  logic                    o_s_ready, o_m_valid, o_acc;
  logic [OW-1:0]           o_m_data;
  logic [3:0]              o_fill;
  logic [TAPS-1:0][DW-1:0] o_win;
  logic                    e_s_ready, e_m_valid;
  logic [OW-1:0]           e_m_data;
  logic [3:0]              e_fill;
  logic [TAPS-1:0][DW-1:0] e_win;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_clear();
    samp_q.delete();
    res_q.delete();
    fill_m = 0;
  endtask

  // one clock: drive at negedge, snapshot DUT and model, advance model at posedge
  task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    logic pp;
    @(negedge clk);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    flush       = fl;
    #1;
    o_s_ready = bus.s_ready;
    o_m_valid = bus.m_valid;
    o_m_data  = bus.m_data;
    o_fill    = fill_cnt;
    o_win     = win;
    e_s_ready = rst_n && !fl && (res_q.size() < RDEPTH);
    e_m_valid = 1'b0;
    if (res_q.size() > 0) e_m_valid = (edges >= res_q[0].avail);
    e_m_data = e_m_valid ? OW'(res_q[0].val) : '0;
    e_fill   = 4'(fill_m);
    e_win    = '0;
    for (int j = 0; j < TAPS && j < samp_q.size(); j++)
      e_win[TAPS-1-j] = DW'(samp_q[samp_q.size()-1-j]);
    o_acc = sv && o_s_ready;
    pp    = o_m_valid && mr && !fl;
    if (pp) begin
      popped.push_back(int'(o_m_data));
      popped_at.push_back(edges);
    end
    @(posedge clk);
    edges++;
    if (fl || !rst_n) begin
      model_clear();
    end else begin
      if (pp && res_q.size() > 0) void'(res_q.pop_front());
      if (o_acc) begin
        samp_q.push_back(int'(sd));
        if (samp_q.size() > TAPS) void'(samp_q.pop_front());
        if (fill_m < TAPS) fill_m++;
        if (fill_m == TAPS) begin
          int s;
          s = 0;
          foreach (samp_q[j]) s += samp_q[j];
          res_q.push_back('{s, edges + FIR_LAT + 1});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== '0) begin n_bad++; $display("FAIL reset_m_data: got %0d want 0", bus.m_data); end
    n_cmp++; if (fill_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", fill_cnt); end
    n_cmp++; if (win !== '0) begin n_bad++; $display("FAIL reset_win: got %h want 0", win); end
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    n_cmp++; if (o_s_ready !== 1'b1) begin n_bad++; $display("FAIL release_s_ready: got %b want 1", o_s_ready); end
    n_cmp++; if (o_fill !== 4'd0) begin n_bad++; $display("FAIL release_fill: got %0d want 0", o_fill); end
    $display("test_reset done");
  endtask

  task automatic test_prime();
    popped.delete();
    for (int i = 1; i <= 12; i++) begin
      tick(i <= 8, DW'(i), 1'b1, 1'b0);
      n_cmp++;
      if (o_fill !== 4'((i - 1 > 8) ? 8 : i - 1)) begin
        n_bad++; $display("FAIL prime_fill[%0d]: got %0d want %0d", i, o_fill, (i - 1 > 8) ? 8 : i - 1);
      end
      n_cmp++;
      if (o_m_valid !== (i == 11)) begin
        n_bad++; $display("FAIL prime_m_valid[%0d]: got %b want %b", i, o_m_valid, i == 11);
      end
    end
    n_cmp++; if (popped.size() != 1) begin n_bad++; $display("FAIL prime_count: got %0d want 1", popped.size()); end
    n_cmp++; if (popped.size() < 1 || popped[0] != 36) begin n_bad++; $display("FAIL prime_value: got %0d want 36", popped.size() ? popped[0] : -1); end
    $display("test_prime done: %0d result(s)", popped.size());
  endtask

  task automatic test_stream();
    int exp_v[5] = '{36, 44, 52, 60, 68};
    tick(1'b0, 8'd0, 1'b1, 1'b1);
    popped.delete();
    popped_at.delete();
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, DW'(i), 1'b1, 1'b0);
      n_cmp++; if (o_s_ready !== 1'b1) begin n_bad++; $display("FAIL stream_s_ready[%0d]: got %b want 1", i, o_s_ready); end
    end
    repeat (4) tick(1'b0, 8'd0, 1'b1, 1'b0);
    n_cmp++; if (popped.size() != 5) begin n_bad++; $display("FAIL stream_count: got %0d want 5", popped.size()); end
    for (int k = 0; k < 5 && k < popped.size(); k++) begin
      n_cmp++; if (popped[k] != exp_v[k]) begin n_bad++; $display("FAIL stream_value[%0d]: got %0d want %0d", k, popped[k], exp_v[k]); end
      n_cmp++; if (popped_at[k] != popped_at[0] + k) begin n_bad++; $display("FAIL stream_gap[%0d]: got edge %0d want %0d", k, popped_at[k], popped_at[0] + k); end
    end
    $display("test_stream done: %0d results", popped.size());
  endtask

  task automatic test_stall();
    int v = 1;
    int accepted = 0;
    logic [TAPS-1:0][DW-1:0] frozen_win;
    tick(1'b0, 8'd0, 1'b1, 1'b1);
    popped.delete();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, DW'(v), 1'b0, 1'b0);
      n_cmp++; if (o_s_ready !== e_s_ready) begin n_bad++; $display("FAIL stall_s_ready[%0d]: got %b want %b", i, o_s_ready, e_s_ready); end
      if (o_acc) begin accepted++; v++; end
    end
    n_cmp++; if (accepted != 11) begin n_bad++; $display("FAIL stall_accepts: got %0d want 11", accepted); end
    for (int k = 0; k < TAPS; k++) frozen_win[k] = DW'(k + 4);
    n_cmp++; if (o_win !== frozen_win) begin n_bad++; $display("FAIL stall_win: got %h want %h", o_win, frozen_win); end
    n_cmp++; if (o_m_valid !== 1'b1) begin n_bad++; $display("FAIL stall_m_valid: got %b want 1", o_m_valid); end
    n_cmp++; if (popped.size() != 0) begin n_bad++; $display("FAIL stall_popped: got %0d want 0", popped.size()); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, DW'(v), 1'b1, 1'b0);
      n_cmp++; if (o_m_data !== e_m_data) begin n_bad++; $display("FAIL stall_rel_data[%0d]: got %0d want %0d", i, o_m_data, e_m_data); end
      if (o_acc) v++;
    end
    n_cmp++; if (popped.size() < 12) begin n_bad++; $display("FAIL stall_rel_count: got %0d want >=12", popped.size()); end
    for (int k = 0; k < popped.size(); k++) begin
      n_cmp++; if (popped[k] != 36 + 8 * k) begin n_bad++; $display("FAIL stall_order[%0d]: got %0d want %0d", k, popped[k], 36 + 8 * k); end
    end
    $display("test_stall done: %0d accepted while stalled, %0d results", accepted, popped.size());
  endtask

  task automatic test_flush();
    tick(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    repeat (3) tick(1'b0, 8'd0, 1'b0, 1'b0);
    tick(1'b0, 8'd0, 1'b0, 1'b0);
    n_cmp++; if (o_m_valid !== 1'b1 || res_q.size() != 2) begin n_bad++; $display("FAIL flush_pre_queue: m_valid %b queued %0d want 1/2", o_m_valid, res_q.size()); end
    popped.delete();
    tick(1'b1, 8'd99, 1'b1, 1'b1);
    n_cmp++; if (o_s_ready !== 1'b0) begin n_bad++; $display("FAIL flush_s_ready: got %b want 0", o_s_ready); end
    for (int i = 1; i <= 11; i++) begin
      tick(i <= 8, DW'(i), 1'b1, 1'b0);
      if (i == 1) begin
        n_cmp++; if (o_m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_m_valid: got %b want 0", o_m_valid); end
        n_cmp++; if (o_fill !== 4'd0) begin n_bad++; $display("FAIL flush_fill: got %0d want 0", o_fill); end
        n_cmp++; if (o_win !== '0) begin n_bad++; $display("FAIL flush_win: got %h want 0", o_win); end
      end
      n_cmp++; if (o_m_valid !== (i == 11)) begin n_bad++; $display("FAIL flush_refill_valid[%0d]: got %b want %b", i, o_m_valid, i == 11); end
    end
    n_cmp++; if (popped.size() != 1 || popped[0] != 36) begin n_bad++; $display("FAIL flush_result: got %0d results first %0d want 1/36", popped.size(), popped.size() ? popped[0] : -1); end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    tick(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL areset_s_ready: got %b want 0", bus.s_ready); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL areset_m_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== '0) begin n_bad++; $display("FAIL areset_m_data: got %0d want 0", bus.m_data); end
    n_cmp++; if (fill_cnt !== 4'd0) begin n_bad++; $display("FAIL areset_fill: got %0d want 0", fill_cnt); end
    n_cmp++; if (win !== '0) begin n_bad++; $display("FAIL areset_win: got %h want 0", win); end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    popped.delete();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 8'd0, 1'b1, 1'b0);
      n_cmp++; if (o_m_valid !== 1'b0) begin n_bad++; $display("FAIL areset_stale[%0d]: got m_valid %b want 0", i, o_m_valid); end
    end
    n_cmp++; if (popped.size() != 0) begin n_bad++; $display("FAIL areset_popped: got %0d want 0", popped.size()); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int nres;
    tick(1'b0, 8'd0, 1'b1, 1'b1);
    popped.delete();
    for (int i = 0; i < 10000; i++) begin
      tick($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 299) == 0);
      n_cmp++; if (o_s_ready !== e_s_ready) begin n_bad++; $display("FAIL rand_s_ready[%0d]: got %b want %b", i, o_s_ready, e_s_ready); end
      n_cmp++; if (o_m_valid !== e_m_valid) begin n_bad++; $display("FAIL rand_m_valid[%0d]: got %b want %b", i, o_m_valid, e_m_valid); end
      n_cmp++; if (o_m_data !== e_m_data) begin n_bad++; $display("FAIL rand_m_data[%0d]: got %0d want %0d", i, o_m_data, e_m_data); end
      n_cmp++; if (o_fill !== e_fill || o_fill > 4'(TAPS)) begin n_bad++; $display("FAIL rand_fill[%0d]: got %0d want %0d", i, o_fill, e_fill); end
      n_cmp++; if (o_win !== e_win) begin n_bad++; $display("FAIL rand_win[%0d]: got %h want %h", i, o_win, e_win); end
    end
    nres = popped.size();
    $display("test_random done: %0d results popped", nres);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_prime();
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
